// File: rtl/axis_bus_arbiter_pkg.sv
// Package for the AXIS bus arbiter: arbiter state encoding, default select
// codes and small helpers shared by the arbiter top and the round-robin picker.
//
// Optional feature macro used by the arbiter: AXIS_ARB_TIMEOUT_EN.
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int unsigned SEL_W        = 8;
    localparam int unsigned SEL_BASE_DEF = 128;
    localparam int unsigned IDLE_SEL_DEF = 0;

    // Mux select code for channel idx.
    function automatic logic [SEL_W-1:0] sel_code(input int unsigned base,
                                                  input int unsigned idx);
        return SEL_W'(base + idx);
    endfunction

    // Width of a channel index; at least one bit so a single channel still has a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_bus_arbiter_if.sv
// Bus-side signal bundle of the AXIS bus arbiter.
//
// master modport (arbiter side):
//   in  fifo_req[N_CH]   channel i holds at least one complete packet
//   in  axis_out_tvalid  post-mux valid fed back
//   in  axis_out_tlast   post-mux last fed back
//   in  axis_out_tready  downstream ready
//   out bus_sel[8]       select code to the mux
//   out grant[N_CH]      one-hot current grant
//   out fifo_rd_en[N_CH] pop strobe to the granted FIFO
//   out busy             packet in progress
//   out timeout_err      pulse on forced release (AXIS_ARB_TIMEOUT_EN only)
// slave modport is the mirror image (FIFO/mux side).
interface axis_bus_arbiter_if #(
    parameter int unsigned N_CH = 4
);

    logic [N_CH-1:0] fifo_req;
    logic            axis_out_tvalid;
    logic            axis_out_tlast;
    logic            axis_out_tready;
    logic [7:0]      bus_sel;
    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] fifo_rd_en;
    logic            busy;
    logic            timeout_err;

    modport master (
        input  fifo_req,
        input  axis_out_tvalid,
        input  axis_out_tlast,
        input  axis_out_tready,
        output bus_sel,
        output grant,
        output fifo_rd_en,
        output busy,
        output timeout_err
    );

    modport slave (
        output fifo_req,
        output axis_out_tvalid,
        output axis_out_tlast,
        output axis_out_tready,
        input  bus_sel,
        input  grant,
        input  fifo_rd_en,
        input  busy,
        input  timeout_err
    );

endinterface

// File: rtl/axis_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: searches the request vector starting
// just after the last winner and wrapping around.
//
// Ports:
//   req[N_CH]        request vector
//   last_ptr[IDX_W]  index of the previous winner
//   onehot[N_CH]     one-hot winner (zero when no request)
//   idx[IDX_W]       winner index (zero when no request)
//   any              at least one request present
module axis_rr_picker
    import axis_arb_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned IDX_W = idx_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [N_CH-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        onehot   = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Offset k=1 is the channel right after the last winner; k=N_CH is the
        // last winner itself, so a lone requester is always re-granted.
        for (int unsigned k = 1; k <= N_CH; k++) begin
            cand     = (32'(last_ptr) + k) % N_CH;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any              = 1'b1;
                idx              = cand_idx;
                onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_bus_arbiter.sv
// Packet-level round-robin arbiter driving bus_sel of a downstream AXIS bus
// mux. A channel keeps the grant for a whole packet, up to and including the
// accepted tlast beat, followed by one idle-select cycle so the mux never
// switches mid-beat. Pop strobes are produced here since the mux has no tready.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    axis_bus_arbiter_if.master (fifo_req, post-mux tvalid/tlast, tready,
//          bus_sel, grant, fifo_rd_en, busy, timeout_err)
//
// Optional feature: define AXIS_ARB_TIMEOUT_EN to release a channel that
// stalls for TIMEOUT_CYC cycles without an accepted beat; timeout_err then
// pulses for one cycle. Without it, XFER waits indefinitely and timeout_err is 0.
module axis_bus_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SEL_BASE    = SEL_BASE_DEF,
    parameter int unsigned IDLE_SEL    = IDLE_SEL_DEF,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic                clk,
    input logic                rst_n,
    axis_bus_arbiter_if.master bus
);

    localparam int unsigned IDX_W = idx_width(N_CH);

    if (N_CH == 0 || N_CH > 127) begin : g_bad_n_ch
        $error("axis_bus_arbiter: N_CH must be in 1..127");
    end
    if (SEL_BASE + N_CH - 1 > 255) begin : g_bad_sel_base
        $error("axis_bus_arbiter: SEL_BASE+N_CH-1 exceeds 255");
    end
    if (IDLE_SEL > 255) begin : g_bad_idle_sel
        $error("axis_bus_arbiter: IDLE_SEL exceeds 255");
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]  grant_q, grant_d;

    logic [N_CH-1:0]  pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             busy;
    logic             beat_ok;

    axis_rr_picker #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_picker (
        .req      (bus.fifo_req),
        .last_ptr (ptr_q),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    assign busy    = (state_q == XFER);
    assign beat_ok = busy & bus.axis_out_tvalid & bus.axis_out_tready;

`ifdef AXIS_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("axis_bus_arbiter: TIMEOUT_CYC must be at least 1");
    end

    logic [STALL_W-1:0] stall_q;
    logic               stall_hit;
    logic               timeout_q, timeout_d;

    assign stall_hit = busy && !beat_ok && (stall_q == STALL_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= (!busy || beat_ok) ? '0 : stall_q + 1'b1;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(N_CH - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
`ifdef AXIS_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            // The GAP cycle already shows IDLE_SEL on the mux, so it arbitrates
            // like IDLE; this keeps back-to-back packets to a single dead cycle.
            IDLE, GAP: begin
                if (pick_any) begin
                    state_d = XFER;
                    idx_d   = pick_idx;
                    grant_d = pick_onehot;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            XFER: begin
                if (beat_ok && bus.axis_out_tlast) begin
                    state_d = GAP;
                    ptr_d   = idx_q;
                end
`ifdef AXIS_ARB_TIMEOUT_EN
                else if (stall_hit) begin
                    state_d   = GAP;
                    ptr_d     = idx_q;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs decode from registered state so an async reset clears them at once.
    assign bus.busy       = busy;
    assign bus.grant      = busy ? grant_q : '0;
    assign bus.fifo_rd_en = beat_ok ? grant_q : '0;
    assign bus.bus_sel    = busy ? sel_code(SEL_BASE, 32'(idx_q)) : SEL_W'(IDLE_SEL);

endmodule

// File: tb/tb_axis_bus_arbiter.sv
// Directed self-checking bench for axis_bus_arbiter (N_CH=4, SEL_BASE=128,
// IDLE_SEL=0, TIMEOUT_CYC=16). Inputs change on the falling edge; outputs are
// sampled 1 ns later. The stall section depends on AXIS_ARB_TIMEOUT_EN.
module tb_axis_bus_arbiter;

    localparam int unsigned N_CH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    axis_bus_arbiter_if #(.N_CH(N_CH)) bus ();

    axis_bus_arbiter #(
        .N_CH        (N_CH),
        .SEL_BASE    (128),
        .IDLE_SEL    (0),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_sel"},   32'(bus.bus_sel), 0);
        check_eq({tag, "_grant"}, 32'(bus.grant),   0);
        check_eq({tag, "_busy"},  32'(bus.busy),    0);
    endtask

    task automatic check_xfer(input string tag, input int unsigned ch);
        check_eq({tag, "_sel"},   32'(bus.bus_sel), 128 + ch);
        check_eq({tag, "_grant"}, 32'(bus.grant),   32'(1) << ch);
        check_eq({tag, "_busy"},  32'(bus.busy),    1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned order [5] = '{0, 1, 2, 3, 0};

        bus.fifo_req        = 4'b1111;
        bus.axis_out_tvalid = 1'b0;
        bus.axis_out_tlast  = 1'b0;
        bus.axis_out_tready = 1'b1;

        // Reset state, then channel 0 wins first.
        repeat (2) @(negedge clk);
        #1;
        check_idle("rst");
        check_eq("rst_terr", 32'(bus.timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_xfer("t1_first", 0);
        bus.axis_out_tvalid = 1'b1;
        bus.axis_out_tlast  = 1'b1;
        #1;
        check_eq("t1_rd", 32'(bus.fifo_rd_en), 4'b0001);
        @(negedge clk);
        bus.fifo_req        = '0;
        bus.axis_out_tvalid = 1'b0;
        bus.axis_out_tlast  = 1'b0;
        #1;
        check_idle("t1_gap");
        @(negedge clk);
        #1;
        check_idle("t1_idle");

        // Channel 2 alone, 3-beat packet; req drops mid-packet without aborting.
        @(negedge clk);
        bus.fifo_req = 4'b0100;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bus.axis_out_tvalid = 1'b1;
            bus.axis_out_tlast  = (b == 2);
            if (b == 1) bus.fifo_req = '0;
            #1;
            check_xfer("t2_beat", 2);
            check_eq("t2_rd", 32'(bus.fifo_rd_en), 4'b0100);
        end
        @(negedge clk);
        bus.axis_out_tvalid = 1'b0;
        bus.axis_out_tlast  = 1'b0;
        #1;
        check_idle("t2_gap");
        check_eq("t2_gap_rd", 32'(bus.fifo_rd_en), 0);
        @(negedge clk);
        #1;
        check_idle("t2_idle");

        // Reset restores the pointer; all channels request, 1-beat packets.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("t3_rst");
        @(negedge clk);
        rst_n        = 1'b1;
        bus.fifo_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            bus.axis_out_tvalid = 1'b1;
            bus.axis_out_tlast  = 1'b1;
            if (n == 4) bus.fifo_req = '0;
            #1;
            check_xfer("t3_rr", order[n]);
            check_eq("t3_rd", 32'(bus.fifo_rd_en), 32'(1) << order[n]);
            @(negedge clk);
            bus.axis_out_tvalid = 1'b0;
            bus.axis_out_tlast  = 1'b0;
            #1;
            check_idle("t3_gap");
        end

        // Channel 1: one beat, then 5 cycles of tready low, then the last beat.
        @(negedge clk);
        bus.fifo_req = 4'b0010;
        @(negedge clk);
        bus.axis_out_tvalid = 1'b1;
        bus.axis_out_tready = 1'b1;
        bus.axis_out_tlast  = 1'b0;
        #1;
        check_xfer("t4_b0", 1);
        check_eq("t4_b0_rd", 32'(bus.fifo_rd_en), 4'b0010);
        repeat (5) begin
            @(negedge clk);
            bus.axis_out_tready = 1'b0;
            #1;
            check_xfer("t4_hold", 1);
            check_eq("t4_hold_rd", 32'(bus.fifo_rd_en), 0);
        end
        @(negedge clk);
        bus.axis_out_tready = 1'b1;
        bus.axis_out_tlast  = 1'b1;
        bus.fifo_req        = '0;
        #1;
        check_xfer("t4_last", 1);
        check_eq("t4_last_rd", 32'(bus.fifo_rd_en), 4'b0010);
        @(negedge clk);
        bus.axis_out_tvalid = 1'b0;
        bus.axis_out_tlast  = 1'b0;
        #1;
        check_idle("t4_gap");
        @(negedge clk);

        // Channel 3 mid-packet, then asynchronous reset away from any edge.
        bus.fifo_req = 4'b1000;
        @(negedge clk);
        bus.axis_out_tvalid = 1'b1;
        bus.axis_out_tlast  = 1'b0;
        #1;
        check_xfer("t5_b0", 3);
        check_eq("t5_b0_rd", 32'(bus.fifo_rd_en), 4'b1000);
        @(negedge clk);
        #1;
        check_xfer("t5_mid", 3);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("t5_async");
        check_eq("t5_async_rd", 32'(bus.fifo_rd_en), 0);
        bus.fifo_req        = '0;
        bus.axis_out_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle("t5_after");

        // Channel 0 with tvalid stuck low; later requests from channel 1 are ignored.
        @(negedge clk);
        bus.fifo_req = 4'b0001;
`ifdef AXIS_ARB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) bus.fifo_req = 4'b0011;
            #1;
            check_xfer("t6_stall", 0);
            check_eq("t6_stall_terr", 32'(bus.timeout_err), 0);
        end
        @(negedge clk);
        #1;
        check_idle("t6_release");
        check_eq("t6_terr", 32'(bus.timeout_err), 1);
        @(negedge clk);
        #1;
        check_xfer("t6_next", 1);
        check_eq("t6_terr_clr", 32'(bus.timeout_err), 0);
        bus.axis_out_tvalid = 1'b1;
        bus.axis_out_tlast  = 1'b1;
        bus.fifo_req        = '0;
        #1;
        check_eq("t6_next_rd", 32'(bus.fifo_rd_en), 4'b0010);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) bus.fifo_req = 4'b0011;
            #1;
            check_xfer("t6_wait", 0);
            check_eq("t6_wait_terr", 32'(bus.timeout_err), 0);
        end
        @(negedge clk);
        bus.axis_out_tvalid = 1'b1;
        bus.axis_out_tlast  = 1'b1;
        bus.fifo_req        = '0;
        #1;
        check_eq("t6_end_rd", 32'(bus.fifo_rd_en), 4'b0001);
`endif
        @(negedge clk);
        bus.axis_out_tvalid = 1'b0;
        bus.axis_out_tlast  = 1'b0;
        #1;
        check_idle("t6_gap");
        check_eq("t6_gap_terr", 32'(bus.timeout_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
